// File: rtl/arb_pkg.sv
// Shared types and default sizing for the arbiter requester agent.
package arb_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    GAP
  } state_t;

  // Command layout at the default widths.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_LEN_W-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
// rst is asynchronous and active-low.
module cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A push offered while full is refused even if a pop happens in the same cycle.
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rdPtr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent for one fixed-priority arbiter slot: queues burst
// commands, requests the bus, and issues one beat per granted cycle.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              req,
  input  logic              grt,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              starve
);

  localparam int CMD_W = DATA_W + LEN_W;
  localparam int WCW   = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT);
  localparam logic [WCW-1:0] WAIT_PRE = WCW'(TIMEOUT - 1);

  state_t                r_state;
  logic [DATA_W-1:0]     r_base;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_beatIdx;
  logic [WCW-1:0]        r_waitCnt;

  logic                  w_full;
  logic                  w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic [CMD_W-1:0]      w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_hasCmd;
  logic                  w_granted;

  assign w_push    = cmd_valid & ~w_full;
  assign w_pop     = (r_state == REQ) & grt & (w_count != '0);
  assign w_hasCmd  = ~w_empty | w_push;
  assign w_granted = (r_state == XFER) & grt;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (cmd_valid),
    .i_wdata ({cmd_data, cmd_len}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // beat_idx is left at len after the final beat so bus_data holds its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_beatIdx <= '0;
      r_waitCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hasCmd) r_state <= REQ;
        end
        REQ: begin
          if (grt) begin
            r_base    <= w_head[CMD_W-1:LEN_W];
            r_len     <= w_head[LEN_W-1:0];
            r_beatIdx <= '0;
            r_waitCnt <= '0;
            r_state   <= XFER;
          end else if (r_waitCnt != WAIT_MAX) begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        XFER: begin
          if (grt) begin
            if (r_beatIdx == r_len) r_state <= GAP;
            else                    r_beatIdx <= r_beatIdx + 1'b1;
          end
        end
        GAP: begin
          r_state <= w_hasCmd ? REQ : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = ~w_full;
  assign req       = (r_state == REQ) | (r_state == XFER);
  assign bus_valid = w_granted;
  assign bus_data  = r_base + DATA_W'(r_beatIdx);
  assign bus_last  = w_granted & (r_beatIdx == r_len);
  // Fires only on the cycle the wait counter steps onto TIMEOUT.
  assign starve    = (r_state == REQ) & ~grt & (r_waitCnt == WAIT_PRE);

endmodule

// File: tb/tb_arb_requester.sv
// Directed self-checking bench for arb_requester: table-driven bursts plus
// hand-written starvation, back-pressure and reset sequences.
module tb_arb_requester;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmdValid = 1'b0;
  logic [7:0] cmdData = '0;
  logic [3:0] cmdLen = '0;
  logic       grtEn = 1'b0;
  logic       grt;
  logic       cmdReady;
  logic       req;
  logic       busValid;
  logic [7:0] busData;
  logic       busLast;
  logic       starve;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    string      name;
    logic       cmdValid;
    logic [7:0] data;
    logic [3:0] len;
    logic       grtEn;
    logic       expReq;
    logic       expReady;
    logic       expValid;
    logic [7:0] expData;
    logic       expLast;
    logic       expStarve;
  } vec_t;

  vec_t vecs[$];

  // The arbiter grants this slot combinationally whenever it requests and is enabled.
  assign grt = grtEn & req;

  always #5 clk = ~clk;

  arb_requester #(
    .DATA_W  (8),
    .LEN_W   (4),
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmdValid),
    .cmd_ready (cmdReady),
    .cmd_data  (cmdData),
    .cmd_len   (cmdLen),
    .req       (req),
    .grt       (grt),
    .bus_valid (busValid),
    .bus_data  (busData),
    .bus_last  (busLast),
    .starve    (starve)
  );

  task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] want);
    testCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input logic eReq, input logic eReady,
                             input logic eValid, input logic [7:0] eData,
                             input logic eLast, input logic eStarve);
    checkField({tag, ".req"},       32'(req),      32'(eReq));
    checkField({tag, ".cmd_ready"}, 32'(cmdReady), 32'(eReady));
    checkField({tag, ".bus_valid"}, 32'(busValid), 32'(eValid));
    checkField({tag, ".bus_data"},  32'(busData),  32'(eData));
    checkField({tag, ".bus_last"},  32'(busLast),  32'(eLast));
    checkField({tag, ".starve"},    32'(starve),   32'(eStarve));
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [3:0] l, input logic g);
    cmdValid = v;
    cmdData  = d;
    cmdLen   = l;
    grtEn    = g;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input string n, input logic v, input logic [7:0] d, input logic [3:0] l,
                        input logic g, input logic eReq, input logic eReady, input logic eValid,
                        input logic [7:0] eData, input logic eLast, input logic eStarve);
    vec_t x;
    x.name = n; x.cmdValid = v; x.data = d; x.len = l; x.grtEn = g;
    x.expReq = eReq; x.expReady = eReady; x.expValid = eValid;
    x.expData = eData; x.expLast = eLast; x.expStarve = eStarve;
    vecs.push_back(x);
  endtask

  initial begin
    // Basic burst: 0x10 len 2 granted immediately.
    addVec("t2_push",  1, 8'h10, 4'd2, 1, 0, 1, 0, 8'h00, 0, 0);
    addVec("t2_req",   0, 8'h00, 4'd0, 1, 1, 1, 0, 8'h00, 0, 0);
    addVec("t2_beat0", 0, 8'h00, 4'd0, 1, 1, 1, 1, 8'h10, 0, 0);
    addVec("t2_beat1", 0, 8'h00, 4'd0, 1, 1, 1, 1, 8'h11, 0, 0);
    addVec("t2_beat2", 0, 8'h00, 4'd0, 1, 1, 1, 1, 8'h12, 1, 0);
    addVec("t2_gap",   0, 8'h00, 4'd0, 1, 0, 1, 0, 8'h12, 0, 0);
    addVec("t2_idle",  0, 8'h00, 4'd0, 1, 0, 1, 0, 8'h12, 0, 0);
    // Pre-emption: grant lost for 3 cycles after the first beat.
    addVec("t3_push",  1, 8'h10, 4'd2, 1, 0, 1, 0, 8'h12, 0, 0);
    addVec("t3_req",   0, 8'h00, 4'd0, 1, 1, 1, 0, 8'h12, 0, 0);
    addVec("t3_beat0", 0, 8'h00, 4'd0, 1, 1, 1, 1, 8'h10, 0, 0);
    addVec("t3_lost0", 0, 8'h00, 4'd0, 0, 1, 1, 0, 8'h11, 0, 0);
    addVec("t3_lost1", 0, 8'h00, 4'd0, 0, 1, 1, 0, 8'h11, 0, 0);
    addVec("t3_lost2", 0, 8'h00, 4'd0, 0, 1, 1, 0, 8'h11, 0, 0);
    addVec("t3_beat1", 0, 8'h00, 4'd0, 1, 1, 1, 1, 8'h11, 0, 0);
    addVec("t3_beat2", 0, 8'h00, 4'd0, 1, 1, 1, 1, 8'h12, 1, 0);
    addVec("t3_gap",   0, 8'h00, 4'd0, 1, 0, 1, 0, 8'h12, 0, 0);
    addVec("t3_idle",  0, 8'h00, 4'd0, 1, 0, 1, 0, 8'h12, 0, 0);

    #1 rst = 1'b0;
    #1 checkOutput("t0_reset", 0, 1, 0, 8'h00, 0, 0);
    #10 rst = 1'b1;
    stepCycle();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].cmdValid, vecs[i].data, vecs[i].len, vecs[i].grtEn);
      @(negedge clk);
      checkOutput(vecs[i].name, vecs[i].expReq, vecs[i].expReady, vecs[i].expValid,
                  vecs[i].expData, vecs[i].expLast, vecs[i].expStarve);
      stepCycle();
    end

    // Reset while idle takes effect without a clock edge.
    applyStimulus(0, 8'h00, 4'd0, 0);
    #2 rst = 1'b0;
    #1 checkOutput("t1_idle_reset", 0, 1, 0, 8'h00, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    stepCycle();

    // Starvation then wrap-around burst.
    applyStimulus(1, 8'hFE, 4'd3, 0);
    @(negedge clk);
    checkOutput("t4_push", 0, 1, 0, 8'h00, 0, 0);
    stepCycle();
    applyStimulus(0, 8'h00, 4'd0, 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t4_wait%0d", k), 1, 1, 0, 8'h00, 0, (k == 8));
      stepCycle();
    end
    grtEn = 1'b1;
    @(negedge clk);
    checkOutput("t4_grant", 1, 1, 0, 8'h00, 0, 0);
    stepCycle();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      checkOutput($sformatf("t4_beat%0d", b), 1, 1, 1, 8'(8'hFE + b), (b == 3), 0);
      stepCycle();
    end
    @(negedge clk);
    checkOutput("t4_gap", 0, 1, 0, 8'h01, 0, 0);
    stepCycle();

    // Back-pressure: five pushes while ungranted, only four fit.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'(8'h30 + i), 4'd0, 0);
      @(negedge clk);
      checkField($sformatf("t5_push%0d.cmd_ready", i), 32'(cmdReady), 32'(i < 4));
      checkField($sformatf("t5_push%0d.req", i), 32'(req), 32'(i > 0));
      stepCycle();
    end
    applyStimulus(0, 8'h00, 4'd0, 1);
    begin
      logic [7:0] lastData;
      lastData = 8'h01;
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        checkOutput($sformatf("t5_req%0d", b), 1, (b != 0), 0, lastData, 0, 0);
        stepCycle();
        @(negedge clk);
        lastData = 8'(8'h30 + b);
        checkOutput($sformatf("t5_beat%0d", b), 1, 1, 1, lastData, 1, 0);
        stepCycle();
        @(negedge clk);
        checkOutput($sformatf("t5_gap%0d", b), 0, 1, 0, lastData, 0, 0);
        stepCycle();
      end
    end
    @(negedge clk);
    checkOutput("t5_idle", 0, 1, 0, 8'h33, 0, 0);
    stepCycle();

    // Reset during the second beat with two commands queued.
    applyStimulus(1, 8'h40, 4'd3, 0);
    @(negedge clk); checkOutput("t6_push0", 0, 1, 0, 8'h33, 0, 0); stepCycle();
    applyStimulus(1, 8'h50, 4'd0, 0);
    @(negedge clk); checkOutput("t6_push1", 1, 1, 0, 8'h33, 0, 0); stepCycle();
    applyStimulus(1, 8'h60, 4'd0, 0);
    @(negedge clk); checkOutput("t6_push2", 1, 1, 0, 8'h33, 0, 0); stepCycle();
    applyStimulus(0, 8'h00, 4'd0, 1);
    @(negedge clk); checkOutput("t6_grant", 1, 1, 0, 8'h33, 0, 0); stepCycle();
    @(negedge clk); checkOutput("t6_beat0", 1, 1, 1, 8'h40, 0, 0); stepCycle();
    @(negedge clk); checkOutput("t6_beat1", 1, 1, 1, 8'h41, 0, 0);
    #1 rst = 1'b0;
    #1 checkOutput("t6_reset", 0, 1, 0, 8'h00, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    stepCycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t6_quiet%0d", i), 0, 1, 0, 8'h00, 0, 0);
      stepCycle();
    end
    applyStimulus(1, 8'h70, 4'd0, 1);
    @(negedge clk); checkOutput("t6_newpush", 0, 1, 0, 8'h00, 0, 0); stepCycle();
    applyStimulus(0, 8'h00, 4'd0, 1);
    @(negedge clk); checkOutput("t6_newreq", 1, 1, 0, 8'h00, 0, 0); stepCycle();
    @(negedge clk); checkOutput("t6_newbeat", 1, 1, 1, 8'h70, 1, 0); stepCycle();
    @(negedge clk); checkOutput("t6_newgap", 0, 1, 0, 8'h70, 0, 0); stepCycle();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
